// File: rtl/dense_layer_mac.sv
// Fully-connected layer MAC: streams one activation plus a weight column per beat,
// then rescales and saturates each row. Optional macro DENSE_LAYER_BIAS_EN adds a per-row bias.
module dense_layer_mac #(
    parameter int datawidth = 11,
    parameter int wwidth    = 8,
    parameter int rows      = 10,
    parameter int cols      = 16,
    parameter int shift     = 7
) (
    input  logic                           clk,
    input  logic                           rst_overall,
    input  logic                           rst_vals,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic signed [datawidth-1:0]    in_data,
    input  logic [rows*wwidth-1:0]         w_col,
    input  logic [rows*datawidth-1:0]      bias,
    output logic                           busy,
    output logic [rows*datawidth-1:0]      out,
    output logic                           layer_done
);

    localparam int ACCW = datawidth + wwidth + $clog2(cols) + 1;
    localparam int CNTW = $clog2(cols) + 1;
    localparam int MULW = datawidth + wwidth;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic signed [ACCW:0] SAT_MAX = (ACCW+1)'((2 ** (datawidth - 1)) - 1);
    localparam logic signed [ACCW:0] SAT_MIN = -SAT_MAX - (ACCW+1)'(1);

    logic [1:0]                   state;
    logic [CNTW-1:0]              count;
    logic signed [ACCW-1:0]       acc_p0 [rows];
    logic signed [wwidth-1:0]     w_r [rows];
    logic signed [MULW-1:0]       mul [rows];
    logic signed [ACCW-1:0]       prod [rows];
    logic signed [ACCW:0]         y [rows];
    logic [rows*datawidth-1:0]    res_packed;
    logic [rows*datawidth-1:0]    out_p1;
    logic                         layer_done_p1;

    function automatic logic signed [datawidth-1:0] sat_fn(input logic signed [ACCW:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[datawidth-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[datawidth-1:0];
        else
            return v[datawidth-1:0];
    endfunction

`ifdef DENSE_LAYER_BIAS_EN
    logic signed [datawidth-1:0]  b_r [rows];
`else
    // Bias port kept for a stable interface; it has no effect in this build.
    logic unused_bias;
    assign unused_bias = ^bias;
`endif

    always_comb begin
        res_packed = '0;
        for (int r = 0; r < rows; r++) begin
            w_r[r]  = $signed(w_col[(rows-r-1)*wwidth +: wwidth]);
            mul[r]  = in_data * w_r[r];
            prod[r] = ACCW'(mul[r]);
`ifdef DENSE_LAYER_BIAS_EN
            b_r[r]  = $signed(bias[(rows-r-1)*datawidth +: datawidth]);
            y[r]    = (ACCW+1)'(acc_p0[r] >>> shift) + (ACCW+1)'(b_r[r]);
`else
            y[r]    = (ACCW+1)'(acc_p0[r] >>> shift);
`endif
            res_packed[(rows-r-1)*datawidth +: datawidth] = sat_fn(y[r]);
        end
    end

    // Stage p0: accumulate beats; stage p1: rescale/saturate into the output register.
    always_ff @(posedge clk) begin
        if (rst_overall || rst_vals) begin
            state         <= IDLE;
            count         <= '0;
            out_p1        <= '0;
            layer_done_p1 <= 1'b0;
            for (int r = 0; r < rows; r++)
                acc_p0[r] <= '0;
        end else begin
            layer_done_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCUM;
                        count <= '0;
                        for (int r = 0; r < rows; r++)
                            acc_p0[r] <= '0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        for (int r = 0; r < rows; r++)
                            acc_p0[r] <= acc_p0[r] + prod[r];
                        count <= count + 1'b1;
                        if (count == CNTW'(cols - 1))
                            state <= FINISH;
                    end
                end
                FINISH: begin
                    out_p1        <= res_packed;
                    layer_done_p1 <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign out        = out_p1;
    assign layer_done = layer_done_p1;

endmodule
